leaf_stream_packetizer: RTL and testbench

- Transmit-side counterpart of the leaf interface's user-to-BFT path: accepts 32-bit words from a user kernel output stream using the vld/ack handshake and emits 49-bit BFT packets to a fixed destination leaf and port.
- Emission is credit-gated. Credits model the free space in the receiver's BRAM buffer, and freespace-update packets returning from the BFT replenish them.
- Sits between one user output stream and the leaf's BFT output arbitration, in the fast (BFT) clock domain.

---
 rtl/leaf_stream_packetizer_if.sv | 34 +++
 rtl/leaf_stream_packetizer.sv | 145 ++++++++++++++
 tb/tb_leaf_stream_packetizer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_stream_packetizer_if.sv
// leaf_stream_packetizer_if: user vld/ack word stream plus BFT packet bus.
// The master drives user words and BFT inputs; the slave is the packetizer.
interface leaf_stream_packetizer_if #(
    parameter int PACKET_BITS  = 49,
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic                    vld_user2interface;
    logic                    ack_interface2user;
    logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
    logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
    logic                    bft_ready;
    logic                    resend;

    modport master (
        output din_leaf_user2interface,
        output vld_user2interface,
        output din_leaf_bft2interface,
        output bft_ready,
        output resend,
        input  ack_interface2user,
        input  dout_leaf_interface2bft
    );

    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        input  din_leaf_bft2interface,
        input  bft_ready,
        input  resend,
        output ack_interface2user,
        output dout_leaf_interface2bft
    );
endinterface

// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer: credit-gated user-word to BFT packet emitter.
// Define LEAF_PKT_STATS_EN for pkt_sent_cnt / credit_stall_cnt outputs.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FIFO_DEPTH            = 4,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int OUT_PORT_ID           = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ap_start,
    input  logic                     stop,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    leaf_stream_packetizer_if.slave  io,
    output logic                     done
`ifdef LEAF_PKT_STATS_EN
    ,
    output logic [31:0]              pkt_sent_cnt,
    output logic [31:0]              credit_stall_cnt
`endif
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = NUM_ADDR_BITS + 2;
    localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int VB       = PACKET_BITS - 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(1 << NUM_ADDR_BITS);
    localparam logic [CW-1:0] CREDIT_UPD = CW'(FREESPACE_UPDATE_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [PAYLOAD_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr, rd_ptr;
    logic [PACKET_BITS-1:0]   out_q;
    logic [NUM_ADDR_BITS-1:0] addr_q;
    logic [CW-1:0]            credits_q, credits_d, credit_sum;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] port_q;
    logic fifo_empty, fifo_full, ack;
    logic start_ok, push, load, consume, upd;
    logic unused_din_bits;

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign start_ok   = ap_start && (state_q == IDLE);
    assign push       = io.vld_user2interface && ack;
    assign consume    = out_q[VB] && io.bft_ready && !io.resend;
    assign load       = (state_q != IDLE) && !fifo_empty &&
                        (credits_q != '0) && !io.resend &&
                        (!out_q[VB] || consume);

    // Freespace updates arrive on the control port tagged with our port id.
    assign upd = io.din_leaf_bft2interface[VB] &&
                 (io.din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0) &&
                 (io.din_leaf_bft2interface[PAYLOAD_BITS-1 -: 4] == 4'(OUT_PORT_ID));
    assign unused_din_bits = ^{io.din_leaf_bft2interface[VB-1 -: NUM_LEAF_BITS],
                               io.din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS],
                               io.din_leaf_bft2interface[PAYLOAD_BITS-5:0]};

    assign io.ack_interface2user      = ack;
    assign io.dout_leaf_interface2bft = io.resend ? '0 : out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  if (ap_start) state_d = RUN;
            RUN: begin
                ack = !fifo_full;
                if (stop) state_d = DRAIN;
            end
            DRAIN: if (fifo_empty && !out_q[VB]) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Update and load on the same edge both apply before saturation.
    always_comb begin
        credit_sum = credits_q + (upd ? CREDIT_UPD : '0) - (load ? CW'(1) : '0);
        credits_d  = (credit_sum > CREDIT_MAX) ? CREDIT_MAX : credit_sum;
        if (start_ok) credits_d = CREDIT_MAX;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= io.din_leaf_user2interface;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_q     <= '0;
            addr_q    <= '0;
            credits_q <= CREDIT_MAX;
            leaf_q    <= '0;
            port_q    <= '0;
        end else begin
            credits_q <= credits_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
                out_q  <= {1'b1, leaf_q, port_q, addr_q, mem[rd_ptr[AW-1:0]]};
                addr_q <= addr_q + 1'b1;
            end else if (consume) begin
                out_q <= '0;
            end
            if (start_ok) begin
                leaf_q <= dest_leaf;
                port_q <= dest_port;
                addr_q <= '0;
            end
        end
    end

`ifdef LEAF_PKT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_sent_cnt     <= '0;
            credit_stall_cnt <= '0;
        end else if (start_ok) begin
            pkt_sent_cnt     <= '0;
            credit_stall_cnt <= '0;
        end else begin
            if (consume) pkt_sent_cnt <= pkt_sent_cnt + 1'b1;
            if (!fifo_empty && credits_q == '0)
                credit_stall_cnt <= credit_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// tb_leaf_stream_packetizer: directed credit/flow scenarios plus random
// traffic, scored against a queue-based model of the packet stream.
module tb_leaf_stream_packetizer;
    logic       clk = 1'b0;
    logic       reset_n, ap_start, stop, done;
    logic [4:0] dest_leaf;
    logic [3:0] dest_port;
`ifdef LEAF_PKT_STATS_EN
    logic [31:0] pkt_sent_cnt, credit_stall_cnt;
`endif

    leaf_stream_packetizer_if bus ();

    leaf_stream_packetizer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ap_start  (ap_start),
        .stop      (stop),
        .dest_leaf (dest_leaf),
        .dest_port (dest_port),
        .io        (bus.slave),
        .done      (done)
`ifdef LEAF_PKT_STATS_EN
        ,
        .pkt_sent_cnt     (pkt_sent_cnt),
        .credit_stall_cnt (credit_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_fail = 0;
    int          n_pkt = 0, n_done = 0, n_push = 0;
    logic [31:0] exp_q [$];
    int          exp_addr = 0;
    logic [4:0]  m_leaf = '0;
    logic [3:0]  m_port = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] upd_pkt(input logic [3:0] port,
                                            input logic [3:0] id);
        return {1'b1, 5'd0, port, 7'd0, id, 28'd0};
    endfunction

    function automatic logic [48:0] exp_pkt(input logic [31:0] w);
        return {1'b1, m_leaf, m_port, 7'(exp_addr), w};
    endfunction

    // Records the handshakes the coming edge will perform, then advances.
    task automatic tick();
        logic [48:0] d;
        logic [31:0] w;
        #1;
        d = bus.dout_leaf_interface2bft;
        if (bus.vld_user2interface && bus.ack_interface2user) begin
            exp_q.push_back(bus.din_leaf_user2interface);
            n_push++;
        end
        if (d[48] && bus.bft_ready) begin
            if (exp_q.size() == 0) begin
                check("pkt_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                w = exp_q.pop_front();
                check("pkt", 64'(d), 64'(exp_pkt(w)));
                exp_addr = (exp_addr + 1) % 128;
            end
            n_pkt++;
        end
        if (done) n_done++;
        @(negedge clk);
    endtask

    task automatic start_run(input logic [4:0] l, input logic [3:0] p);
        dest_leaf = l;
        dest_port = p;
        ap_start  = 1'b1;
        tick();
        ap_start  = 1'b0;
        m_leaf    = l;
        m_port    = p;
        exp_addr  = 0;
    endtask

    task automatic send(input logic [31:0] w);
        int b;
        b = n_push;
        bus.din_leaf_user2interface = w;
        bus.vld_user2interface = 1'b1;
        for (int i = 0; i < 100 && n_push == b; i++) tick();
        bus.vld_user2interface = 1'b0;
        check("send", 64'(n_push - b), 64'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("wait_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic stream_until_stall(output int got);
        int base, idle, b;
        base = n_pkt;
        idle = 0;
        bus.vld_user2interface = 1'b1;
        bus.bft_ready = 1'b1;
        bus.resend = 1'b0;
        for (int i = 0; i < 2000 && idle < 20; i++) begin
            bus.din_leaf_user2interface = $urandom;
            b = n_pkt;
            tick();
            idle = (n_pkt == b) ? idle + 1 : 0;
        end
        got = n_pkt - base;
    endtask

    // Write one word, then land a matching update on the edge that loads it.
    task automatic coincide();
        bus.din_leaf_user2interface = $urandom;
        bus.vld_user2interface = 1'b1;
        tick();
        bus.vld_user2interface = 1'b0;
        bus.din_leaf_bft2interface = upd_pkt(4'd0, 4'd1);
        tick();
        bus.din_leaf_bft2interface = '0;
        wait_empty();
    endtask

    task automatic drain();
        int base;
        base = n_pkt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        bus.vld_user2interface = 1'b0;
        #1 check("drain_ack", 64'(bus.ack_interface2user), 64'd0);
        bus.bft_ready = 1'b1;
        bus.resend = 1'b0;
        n_done = 0;
        for (int i = 0; i < 300 && n_done == 0; i++) begin
            bus.din_leaf_bft2interface = upd_pkt(4'd0, 4'd1);
            tick();
        end
        bus.din_leaf_bft2interface = '0;
        repeat (4) tick();
        check("drain_done", 64'(n_done), 64'd1);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("idle_ack", 64'(bus.ack_interface2user), 64'd0);
    endtask

    initial begin
        int          got, base;
        logic [31:0] w;
        logic [48:0] e;
        reset_n = 1'b0;
        ap_start = 1'b0;
        stop = 1'b0;
        dest_leaf = '0;
        dest_port = '0;
        bus.din_leaf_user2interface = '0;
        bus.vld_user2interface = 1'b0;
        bus.din_leaf_bft2interface = '0;
        bus.bft_ready = 1'b1;
        bus.resend = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rst_ack", 64'(bus.ack_interface2user), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        n_done = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        check("stop_idle", 64'(n_done), 64'd0);
        check("idle_ack0", 64'(bus.ack_interface2user), 64'd0);

        start_run(5'd5, 4'd3);
        #1 check("ack_run", 64'(bus.ack_interface2user), 64'd1);
        base = n_pkt;
        send(32'hA);
        send(32'hB);
        send(32'hC);
        dest_leaf = 5'd9;
        dest_port = 4'd7;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        wait_empty();
        check("basic_pkts", 64'(n_pkt - base), 64'd3);
`ifdef LEAF_PKT_STATS_EN
        check("stats_sent", 64'(pkt_sent_cnt), 64'd3);
`endif
        send(32'hD);
        wait_empty();
        drain();

        start_run(5'd2, 4'd9);
        stream_until_stall(got);
        check("exh_pkts", 64'(got), 64'd128);
        check("exh_ack", 64'(bus.ack_interface2user), 64'd0);
        check("exh_fifo", 64'(exp_q.size()), 64'd4);
        bus.vld_user2interface = 1'b0;
        base = n_pkt;
        bus.din_leaf_bft2interface = upd_pkt(4'd2, 4'd1);
        tick();
        bus.din_leaf_bft2interface = upd_pkt(4'd0, 4'd2);
        tick();
        e = upd_pkt(4'd0, 4'd1);
        e[48] = 1'b0;
        bus.din_leaf_bft2interface = e;
        tick();
        bus.din_leaf_bft2interface = '0;
        repeat (10) tick();
        check("decoy_pkts", 64'(n_pkt - base), 64'd0);
        bus.din_leaf_bft2interface = upd_pkt(4'd0, 4'd1);
        tick();
        bus.din_leaf_bft2interface = '0;
        stream_until_stall(got);
        check("upd_pkts", 64'(got), 64'd64);
        bus.vld_user2interface = 1'b0;
        drain();

        start_run(5'd1, 4'd6);
        for (int i = 0; i < 100; i++) send($urandom);
        wait_empty();
        coincide();
        stream_until_stall(got);
        check("coinc_pkts", 64'(got), 64'd91);
        bus.vld_user2interface = 1'b0;
        drain();

        start_run(5'd7, 4'd1);
        for (int i = 0; i < 28; i++) send($urandom);
        wait_empty();
        coincide();
        bus.din_leaf_bft2interface = upd_pkt(4'd0, 4'd1);
        tick();
        bus.din_leaf_bft2interface = '0;
        tick();
        stream_until_stall(got);
        check("sat_pkts", 64'(got), 64'd128);
        bus.vld_user2interface = 1'b0;
        drain();

        start_run(5'd12, 4'd4);
        bus.bft_ready = 1'b0;
        w = $urandom;
        send(w);
        #1 check("lat_min", 64'(bus.dout_leaf_interface2bft[48]), 64'd0);
        tick();
        e = exp_pkt(w);
        base = n_pkt;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_hold", 64'(bus.dout_leaf_interface2bft), 64'(e));
            tick();
        end
        check("bp_nocons", 64'(n_pkt - base), 64'd0);
        bus.bft_ready = 1'b1;
        tick();
        check("bp_accept", 64'(n_pkt - base), 64'd1);

        bus.bft_ready = 1'b0;
        w = $urandom;
        send(w);
        tick();
        e = exp_pkt(w);
        base = n_pkt;
        bus.bft_ready = 1'b1;
        bus.resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("rs_zero", 64'(bus.dout_leaf_interface2bft), 64'd0);
            tick();
        end
        check("rs_nocons", 64'(n_pkt - base), 64'd0);
        bus.resend = 1'b0;
        #1 check("rs_back", 64'(bus.dout_leaf_interface2bft), 64'(e));
        tick();
        check("rs_cons", 64'(n_pkt - base), 64'd1);
        drain();

        start_run(5'd3, 4'd2);
        bus.bft_ready = 1'b0;
        base = n_pkt;
        for (int i = 0; i < 3; i++) send($urandom);
        drain();
        check("drain_pkts", 64'(n_pkt - base), 64'd3);

        start_run(5'(($urandom)), 4'(($urandom)));
        for (int i = 0; i < 1500; i++) begin
            bus.vld_user2interface = 1'($urandom);
            bus.din_leaf_user2interface = $urandom;
            bus.bft_ready = ($urandom % 4) != 0;
            bus.resend = ($urandom % 8) == 0;
            if ($urandom % 6 == 0)
                bus.din_leaf_bft2interface = upd_pkt(4'd0, 4'd1);
            else
                bus.din_leaf_bft2interface = {17'($urandom), 32'($urandom)};
            tick();
        end
        drain();

        start_run(5'd4, 4'd8);
        bus.bft_ready = 1'b0;
        send($urandom);
        send($urandom);
        tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rst_mid_ack", 64'(bus.ack_interface2user), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        bus.bft_ready = 1'b1;
        tick();
        start_run(5'd4, 4'd8);
        base = n_pkt;
        send(32'h1234_5678);
        wait_empty();
        check("rst_after", 64'(n_pkt - base), 64'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
